// File: rtl/uart.sv
// UART with parameterised frame format and a multi-word transmit command.
// Optional macro UART_RX_GLITCH_FILTER_EN re-checks the start bit at mid-bit before committing.
module uart #(
  parameter int CMD_WIDTH  = 16,
  parameter int READ_WIDTH = 8,
  parameter int BR         = 115200,
  parameter int CHEAK      = 1,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CMD_WIDTH-1:0]  cmd_in,
  input  logic                  cmd_vld,
  input  logic                  rx,
  output logic                  tx,
  output logic                  read_rdy,
  output logic [READ_WIDTH-1:0] read_data,
  output logic                  cmd_rdy
);

  localparam int DIV    = CLK_FREQ / BR;
  localparam int HALF   = DIV / 2;
  localparam int WORDS  = CMD_WIDTH / READ_WIDTH;
  localparam int CNT_W  = $clog2(DIV + 1);
  localparam int BIT_W  = $clog2(READ_WIDTH + 1);
  localparam int WORD_W = $clog2(WORDS + 1);

  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(READ_WIDTH - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Value the parity bit must carry for a given data word (odd or even mode).
  function automatic logic parity_bit(input logic [READ_WIDTH-1:0] d);
    if (CHEAK == 2) return ^d;
    else            return ~^d;
  endfunction

  // ---------------- transmitter ----------------
  state_t                tx_state;
  state_t                tx_next;
  logic [CNT_W-1:0]      tx_cnt;
  logic [BIT_W-1:0]      tx_bit;
  logic [WORD_W-1:0]     tx_word;
  logic [CMD_WIDTH-1:0]  tx_shift;
  logic [CMD_WIDTH-1:0]  tx_shift_nxt;
  logic [READ_WIDTH-1:0] tx_data;
  logic [READ_WIDTH-1:0] tx_cur;
  logic                  tx_bit_done;

  assign tx_cur       = tx_shift[CMD_WIDTH-1 -: READ_WIDTH];
  assign tx_shift_nxt = tx_shift << READ_WIDTH;
  assign tx_bit_done  = (tx_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) tx_state <= S_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tx      = 1'b1;
    cmd_rdy = 1'b0;
    case (tx_state)
      S_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_vld) tx_next = S_START;
      end
      S_START: begin
        tx = 1'b0;
        if (tx_bit_done) tx_next = S_DATA;
      end
      S_DATA: begin
        tx = tx_data[0];
        if (tx_bit_done && tx_bit == BIT_LAST) begin
          if (CHEAK != 0) tx_next = S_PARITY;
          else            tx_next = S_STOP;
        end
      end
      S_PARITY: begin
        tx = parity_bit(tx_cur);
        if (tx_bit_done) tx_next = S_STOP;
      end
      S_STOP: begin
        if (tx_bit_done) begin
          if (tx_word == WORD_LAST) tx_next = S_IDLE;
          else                      tx_next = S_START;
        end
      end
      default: tx_next = S_IDLE;
    endcase
  end

  // Words leave most significant first; tx_data is the serialiser for the current word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_word  <= '0;
      tx_shift <= '0;
      tx_data  <= '0;
    end else if (tx_state == S_IDLE) begin
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_word <= '0;
      if (cmd_vld) begin
        tx_shift <= cmd_in;
        tx_data  <= cmd_in[CMD_WIDTH-1 -: READ_WIDTH];
      end
    end else begin
      tx_cnt <= tx_bit_done ? '0 : tx_cnt + 1'b1;
      if (tx_bit_done) begin
        case (tx_state)
          S_DATA: begin
            tx_data <= tx_data >> 1;
            tx_bit  <= (tx_bit == BIT_LAST) ? '0 : tx_bit + 1'b1;
          end
          S_STOP: begin
            tx_word  <= tx_word + 1'b1;
            tx_shift <= tx_shift_nxt;
            tx_data  <= tx_shift_nxt[CMD_WIDTH-1 -: READ_WIDTH];
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- receiver ----------------
  state_t                rx_state;
  state_t                rx_next;
  logic                  rx_s1;
  logic                  rx_s2;
  logic                  rx_s3;
  logic [CNT_W-1:0]      rx_cnt;
  logic [BIT_W-1:0]      rx_bit;
  logic [READ_WIDTH-1:0] rx_shift;
  logic                  rx_par;
  logic                  rx_half;
  logic                  rx_full;
  logic                  rx_fall;
  logic                  rx_par_ok;
  logic                  rx_frame_ok;

  assign rx_half     = (rx_cnt == HALF_LAST);
  assign rx_full     = (rx_cnt == DIV_LAST);
  assign rx_fall     = rx_s3 & ~rx_s2;
  assign rx_par_ok   = (CHEAK == 0) ? 1'b1 : (rx_par == parity_bit(rx_shift));
  assign rx_frame_ok = (rx_state == S_STOP) && rx_full && rx_s2 && rx_par_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) rx_state <= S_IDLE;
    else        rx_state <= rx_next;
  end

  // Requiring a 1->0 edge means a framing error re-arms only after rx returns high.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE: begin
        if (rx_fall) rx_next = S_START;
      end
      S_START: begin
        if (rx_half) begin
`ifdef UART_RX_GLITCH_FILTER_EN
          if (rx_s2) rx_next = S_IDLE;
          else       rx_next = S_DATA;
`else
          rx_next = S_DATA;
`endif
        end
      end
      S_DATA: begin
        if (rx_full && rx_bit == BIT_LAST) begin
          if (CHEAK != 0) rx_next = S_PARITY;
          else            rx_next = S_STOP;
        end
      end
      S_PARITY: begin
        if (rx_full) rx_next = S_STOP;
      end
      S_STOP: begin
        if (rx_full) rx_next = S_IDLE;
      end
      default: rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_par    <= 1'b0;
      read_data <= '0;
      read_rdy  <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      read_rdy <= rx_frame_ok;
      if (rx_frame_ok) read_data <= rx_shift;

      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
        end
        S_START: rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
        default: rx_cnt <= rx_full ? '0 : rx_cnt + 1'b1;
      endcase

      if (rx_state == S_DATA && rx_full) begin
        rx_shift <= {rx_s2, rx_shift[READ_WIDTH-1:1]};
        rx_bit   <= (rx_bit == BIT_LAST) ? '0 : rx_bit + 1'b1;
      end
      if (rx_state == S_PARITY && rx_full) rx_par <= rx_s2;
    end
  end

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart: stimulus queues expected words, independent monitors
// decode the tx line and watch read_rdy, comparing against a frame-level model.
module tb_uart;

  localparam int CMD_WIDTH  = 16;
  localparam int READ_WIDTH = 8;
  localparam int BR         = 115200;
  localparam int CHEAK      = 1;
  localparam int CLK_FREQ   = 100_000_000;

  localparam int DIV        = CLK_FREQ / BR;
  localparam int WORDS      = CMD_WIDTH / READ_WIDTH;
  localparam int PAR_BITS   = (CHEAK != 0) ? 1 : 0;
  localparam int FRAME_BITS = 2 + READ_WIDTH + PAR_BITS;
  localparam int TX_BUSY    = WORDS * FRAME_BITS * DIV;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [CMD_WIDTH-1:0]  cmd_in = '0;
  logic                  cmd_vld = 1'b0;
  logic                  rx = 1'b1;
  logic                  tx;
  logic                  read_rdy;
  logic [READ_WIDTH-1:0] read_data;
  logic                  cmd_rdy;

  int vectors = 0;
  int miscompares = 0;

  logic [READ_WIDTH-1:0] tx_exp[$];
  logic [READ_WIDTH-1:0] rx_exp[$];
  logic [READ_WIDTH-1:0] rx_last_good = '0;
  bit                    tx_mon_en = 1'b1;
  bit                    rdy_prev = 1'b0;
  logic [FRAME_BITS-1:0] mon_bits;

  uart #(
    .CMD_WIDTH (CMD_WIDTH),
    .READ_WIDTH(READ_WIDTH),
    .BR        (BR),
    .CHEAK     (CHEAK),
    .CLK_FREQ  (CLK_FREQ)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_in   (cmd_in),
    .cmd_vld  (cmd_vld),
    .rx       (rx),
    .tx       (tx),
    .read_rdy (read_rdy),
    .read_data(read_data),
    .cmd_rdy  (cmd_rdy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole serial frame, bit 0 first on the wire: start, data LSB first, parity, stop.
  function automatic logic [FRAME_BITS-1:0] frameBits(input logic [READ_WIDTH-1:0] w, input bit bad);
    int   ones;
    logic p;
    ones = $countones(w);
    p = ((ones % 2) == 0) ? (CHEAK == 1) : (CHEAK == 2);
    if (bad) p = ~p;
    frameBits = '0;
    for (int i = 0; i < READ_WIDTH; i++) frameBits[1 + i] = w[i];
    if (PAR_BITS == 1) frameBits[READ_WIDTH + 1] = p;
    frameBits[FRAME_BITS - 1] = 1'b1;
  endfunction

  function automatic logic [READ_WIDTH-1:0] wordOf(input logic [CMD_WIDTH-1:0] cmd, input int w);
    return READ_WIDTH'(cmd >> ((WORDS - 1 - w) * READ_WIDTH));
  endfunction

  // Issue one command; cmd_vld stays up for 'hold' cycles and is pulsed again mid-transfer.
  task automatic applyStimulus(input logic [CMD_WIDTH-1:0] cmd, input int hold);
    int waitCnt = 0;
    int busy = 0;
    int held = 1;
    @(negedge clk);
    cmd_in  = cmd;
    cmd_vld = 1'b1;
    while (cmd_rdy !== 1'b1 && waitCnt < 2 * TX_BUSY) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("cmd_rdy_before_handshake", 32'(cmd_rdy), 32'(1));
    for (int w = 0; w < WORDS; w++) tx_exp.push_back(wordOf(cmd, w));
    @(negedge clk);
    checkOutput("tx_start_latency", 32'(tx), 32'(0));
    cmd_in = CMD_WIDTH'($urandom);
    while (cmd_rdy === 1'b0 && busy < 2 * TX_BUSY) begin
      busy++;
      cmd_vld = (held < hold) || (busy == TX_BUSY / 2);
      if (busy == TX_BUSY / 2) cmd_in = CMD_WIDTH'($urandom);
      held++;
      @(negedge clk);
    end
    cmd_vld = 1'b0;
    checkOutput("cmd_rdy_low_cycles", 32'(busy), 32'(TX_BUSY));
  endtask

  task automatic driveRxFrame(input logic [READ_WIDTH-1:0] word, input bit bad);
    logic [FRAME_BITS-1:0] f;
    f = frameBits(word, bad);
    if (!bad) rx_exp.push_back(word);
    for (int b = 0; b < FRAME_BITS; b++) begin
      rx = f[b];
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
    if (!bad) rx_last_good = word;
  endtask

  // Decode whatever appears on tx by mid-bit sampling and compare against queued words.
  initial begin : txMonitor
    forever begin
      @(negedge clk);
      if (tx_mon_en && rst_n === 1'b1 && tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        mon_bits[0] = tx;
        for (int b = 1; b < FRAME_BITS; b++) begin
          repeat (DIV) @(negedge clk);
          mon_bits[b] = tx;
        end
        if (tx_exp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL tx_unexpected_frame: actual frame 0x%0h, expected no frame", mon_bits);
        end else begin
          checkOutput("tx_frame", 32'(mon_bits), 32'(frameBits(tx_exp.pop_front(), 1'b0)));
        end
      end
    end
  end

  initial begin : rxMonitor
    forever begin
      @(negedge clk);
      if (rdy_prev) checkOutput("read_rdy_pulse_width", 32'(read_rdy), 32'(0));
      if (read_rdy === 1'b1 && !rdy_prev) begin
        if (rx_exp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL rx_unexpected_word: actual read_rdy with 0x%0h, expected none", read_data);
        end else begin
          checkOutput("read_data", 32'(read_data), 32'(rx_exp.pop_front()));
        end
      end
      rdy_prev = (read_rdy === 1'b1);
    end
  end

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog: actual cycle count over budget, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int drain;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tx", 32'(tx), 32'(1));
    checkOutput("reset_cmd_rdy", 32'(cmd_rdy), 32'(1));
    checkOutput("reset_read_rdy", 32'(read_rdy), 32'(0));
    checkOutput("reset_read_data", 32'(read_data), 32'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] phase 1: fixed command and fixed rx frames");
    fork
      applyStimulus(16'hAAAA, 10);
      begin
        driveRxFrame(8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        driveRxFrame(8'h5A, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("read_data_hold_bad_parity", 32'(read_data), 32'(rx_last_good));
      end
    join

    $display("[TB] phase 2: random command, rx glitch, random rx frame");
    fork
      applyStimulus(CMD_WIDTH'($urandom), 1 + int'($urandom_range(0, 20)));
      begin
`ifndef UART_RX_GLITCH_FILTER_EN
        rx_exp.push_back('1);
`endif
        for (int i = 0; i < 20; i++) begin
          rx = (i % 2 == 1);
          @(negedge clk);
        end
        rx = 1'b1;
        repeat (FRAME_BITS * DIV + 50) @(negedge clk);
`ifdef UART_RX_GLITCH_FILTER_EN
        checkOutput("read_data_hold_glitch", 32'(read_data), 32'(rx_last_good));
`else
        rx_last_good = '1;
`endif
        driveRxFrame(READ_WIDTH'($urandom), 1'b0);
      end
    join

    $display("[TB] phase 3: reset in the middle of a transmit frame");
    tx_mon_en = 1'b0;
    @(negedge clk);
    cmd_in  = CMD_WIDTH'($urandom);
    cmd_vld = 1'b1;
    drain = 0;
    while (cmd_rdy !== 1'b1 && drain < 2 * TX_BUSY) begin
      @(negedge clk);
      drain++;
    end
    @(negedge clk);
    cmd_vld = 1'b0;
    repeat (1000 + int'($urandom_range(0, 5000))) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_tx", 32'(tx), 32'(1));
    checkOutput("midreset_cmd_rdy", 32'(cmd_rdy), 32'(1));
    checkOutput("midreset_read_rdy", 32'(read_rdy), 32'(0));
    checkOutput("midreset_read_data", 32'(read_data), 32'(0));
    rst_n = 1'b1;
    rx_last_good = '0;
    repeat (5) @(negedge clk);
    tx_mon_en = 1'b1;
    applyStimulus(CMD_WIDTH'($urandom), 1);

    drain = 0;
    while ((tx_exp.size() != 0 || rx_exp.size() != 0) && drain < 2 * FRAME_BITS * DIV) begin
      @(negedge clk);
      drain++;
    end
    checkOutput("tx_queue_drained", 32'(tx_exp.size()), 32'(0));
    checkOutput("rx_queue_drained", 32'(rx_exp.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
